// File: rtl/gen_chain_batch.sv
// Batched WOTS chaining engine: applies F to up to NUM_LANES chains, each with
// its own start step and step count, through one shared external hash port.
module gen_chain_batch #(
  parameter int WOTS_W                = 16,
  parameter int WOTS_LOG_W            = $clog2(WOTS_W),
  parameter int NUM_LANES             = 67,
  parameter int LANE_W                = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int KEY_LEN               = 256,
  parameter int XMSS_HASH_PADDING_F   = 0,
  parameter int XMSS_HASH_PADDING_PRF = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [KEY_LEN-1:0]      pub_seed,
  input  logic [255:0]            adrs_in,
  input  logic                    cfg_we,
  input  logic [LANE_W-1:0]       cfg_lane,
  input  logic [KEY_LEN-1:0]      cfg_data,
  input  logic [WOTS_LOG_W-1:0]   cfg_start_step,
  input  logic [WOTS_LOG_W-1:0]   cfg_steps,
  input  logic [LANE_W-1:0]       rd_lane,
  output logic [KEY_LEN-1:0]      rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             hash_calls,
  output logic                    hash_start,
  output logic [3*KEY_LEN-1:0]    hash_data_in,
  input  logic                    hash_done,
  input  logic [KEY_LEN-1:0]      hash_data_out
);
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_SETUP     = 4'd1;
  localparam logic [3:0] S_PRF_KEY   = 4'd2;
  localparam logic [3:0] S_WAIT_KEY  = 4'd3;
  localparam logic [3:0] S_PRF_MASK  = 4'd4;
  localparam logic [3:0] S_WAIT_MASK = 4'd5;
  localparam logic [3:0] S_F_ISSUE   = 4'd6;
  localparam logic [3:0] S_WAIT_F    = 4'd7;
  localparam logic [3:0] S_WRITE     = 4'd8;
  localparam logic [3:0] S_FINISH    = 4'd9;

  localparam logic [KEY_LEN-1:0] PAD_F   = KEY_LEN'(XMSS_HASH_PADDING_F);
  localparam logic [KEY_LEN-1:0] PAD_PRF = KEY_LEN'(XMSS_HASH_PADDING_PRF);

  logic [3:0]              state;
  logic [LANE_W-1:0]       ptr;
  logic [WOTS_LOG_W-1:0]   j, rem;
  logic [KEY_LEN-1:0]      v, key, bm, seed;
  logic [255:96]           adrs_hi;

  logic [NUM_LANES-1:0][KEY_LEN-1:0]    lane_val;
  logic [NUM_LANES-1:0][WOTS_LOG_W-1:0] lane_ss, lane_st;

  logic cfg_wr, wb;
  assign cfg_wr = cfg_we && (state == S_IDLE);
  assign wb     = (state == S_WRITE);

  // Lane file: config writes only in IDLE, result write-back in place.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [KEY_LEN-1:0]    val_q;
    logic [WOTS_LOG_W-1:0] ss_q, st_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        val_q <= '0;
        ss_q  <= '0;
        st_q  <= '0;
      end else if (cfg_wr && cfg_lane == LANE_W'(i)) begin
        val_q <= cfg_data;
        ss_q  <= cfg_start_step;
        st_q  <= cfg_steps;
      end else if (wb && ptr == LANE_W'(i)) begin
        val_q <= v;
      end
    end
    assign lane_val[i] = val_q;
    assign lane_ss[i]  = ss_q;
    assign lane_st[i]  = st_q;
  end

  logic [WOTS_LOG_W-1:0] cur_ss, cur_st, room, k_eff;
  logic                  last;
  assign cur_ss = lane_ss[ptr];
  assign cur_st = lane_st[ptr];
  assign room   = WOTS_LOG_W'(WOTS_W - 1) - cur_ss;
  assign k_eff  = (cur_st > room) ? room : cur_st;
  assign last   = (int'(ptr) == NUM_LANES - 1);

  logic unused_adrs_lo;
  assign unused_adrs_lo = ^adrs_in[95:0];

  logic [255:0] adrs_k, adrs_m;
  assign adrs_k = {adrs_hi, 32'(ptr), 32'(j), 32'd0};
  assign adrs_m = {adrs_hi, 32'(ptr), 32'(j), 32'd1};

  assign busy       = (state != S_IDLE) && (state != S_FINISH);
  assign done       = (state == S_FINISH);
  assign hash_start = (state == S_PRF_KEY) || (state == S_PRF_MASK) || (state == S_F_ISSUE);

  // Request is decoded from state so it stays stable across the wait.
  always_comb begin
    hash_data_in = '0;
    case (state)
      S_PRF_KEY,  S_WAIT_KEY:  hash_data_in = {PAD_PRF, seed, KEY_LEN'(adrs_k)};
      S_PRF_MASK, S_WAIT_MASK: hash_data_in = {PAD_PRF, seed, KEY_LEN'(adrs_m)};
      S_F_ISSUE,  S_WAIT_F:    hash_data_in = {PAD_F, key, v ^ bm};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= (int'(rd_lane) < NUM_LANES) ? lane_val[rd_lane] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      j          <= '0;
      rem        <= '0;
      v          <= '0;
      key        <= '0;
      bm         <= '0;
      seed       <= '0;
      adrs_hi    <= '0;
      err        <= 1'b0;
      hash_calls <= '0;
    end else begin
      if (hash_start && hash_calls != 16'hFFFF) hash_calls <= hash_calls + 16'd1;
      case (state)
        S_IDLE: if (start) begin
          state      <= S_SETUP;
          ptr        <= '0;
          hash_calls <= '0;
          err        <= 1'b0;
          seed       <= pub_seed;
          adrs_hi    <= adrs_in[255:96];
        end
        S_SETUP: begin
          v   <= lane_val[ptr];
          j   <= cur_ss;
          rem <= k_eff;
          if (k_eff != cur_st) err <= 1'b1;
          state <= (k_eff == '0) ? S_WRITE : S_PRF_KEY;
        end
        S_PRF_KEY:   state <= S_WAIT_KEY;
        S_WAIT_KEY:  if (hash_done) begin
          key   <= hash_data_out;
          state <= S_PRF_MASK;
        end
        S_PRF_MASK:  state <= S_WAIT_MASK;
        S_WAIT_MASK: if (hash_done) begin
          bm    <= hash_data_out;
          state <= S_F_ISSUE;
        end
        S_F_ISSUE:   state <= S_WAIT_F;
        S_WAIT_F:    if (hash_done) begin
          v     <= hash_data_out;
          j     <= j + 1'b1;
          rem   <= rem - 1'b1;
          state <= (rem == WOTS_LOG_W'(1)) ? S_WRITE : S_PRF_KEY;
        end
        S_WRITE: begin
          if (last) state <= S_FINISH;
          else begin
            ptr   <= ptr + 1'b1;
            state <= S_SETUP;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gen_chain_batch.sv
// Directed bench for gen_chain_batch: 4 lanes, W=16, with a latency-4 hash stub.
module tb_gen_chain_batch;
  localparam int NL = 4, KL = 256, LW = 2, LG = 4, L = 4;

  logic clk = 1'b0, reset;
  always #5 clk = ~clk;

  logic start, cfg_we, busy, done, err, hash_start, hash_done;
  logic [KL-1:0] pub_seed, cfg_data, rd_data, hash_data_out;
  logic [255:0] adrs_in;
  logic [LW-1:0] cfg_lane, rd_lane;
  logic [LG-1:0] cfg_start_step, cfg_steps;
  logic [15:0] hash_calls;
  logic [3*KL-1:0] hash_data_in;

  gen_chain_batch #(.WOTS_W(16), .NUM_LANES(NL), .KEY_LEN(KL)) dut (
    .clk(clk), .reset(reset), .start(start), .pub_seed(pub_seed), .adrs_in(adrs_in),
    .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_data(cfg_data),
    .cfg_start_step(cfg_start_step), .cfg_steps(cfg_steps), .rd_lane(rd_lane),
    .rd_data(rd_data), .busy(busy), .done(done), .err(err), .hash_calls(hash_calls),
    .hash_start(hash_start), .hash_data_in(hash_data_in), .hash_done(hash_done),
    .hash_data_out(hash_data_out));

  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] hfn(input logic [255:0] pad, input logic [255:0] k,
                                       input logic [255:0] p);
    return (k ^ {p[254:0], p[255]}) + pad + 256'd1;
  endfunction

  logic [255:0] SEED, ADRS;
  function automatic logic [255:0] mk_adrs(input int lane, input int jj, input int m);
    return {ADRS[255:96], lane[31:0], jj[31:0], m[31:0]};
  endfunction

  logic [767:0] got_q[$], exp_q[$];
  int rst_epoch = 0;

  // Hash stub: result appears L cycles after the request cycle.
  initial begin
    logic [767:0] req;
    int ep;
    hash_done = 1'b0;
    hash_data_out = '0;
    forever begin
      @(negedge clk);
      if (hash_start) begin
        req = hash_data_in;
        ep = rst_epoch;
        got_q.push_back(req);
        repeat (L) @(posedge clk);
        #1;
        if (ep == rst_epoch) check("hd_stable", hash_data_in, req);
        hash_done = 1'b1;
        hash_data_out = hfn(req[767:512], req[511:256], req[255:0]);
        @(posedge clk);
        #1 hash_done = 1'b0;
      end
    end
  end

  // Expected chain for k steps from s, also queues expected hash requests.
  task automatic model_lane(input int lane, input int s, input int k,
                            input logic [255:0] vin, output logic [255:0] vout);
    logic [255:0] a, kk, bm, vv;
    vv = vin;
    for (int t = 0; t < k; t++) begin
      a = mk_adrs(lane, s + t, 0);
      exp_q.push_back({256'd3, SEED, a});
      kk = hfn(256'd3, SEED, a);
      a = mk_adrs(lane, s + t, 1);
      exp_q.push_back({256'd3, SEED, a});
      bm = hfn(256'd3, SEED, a);
      exp_q.push_back({256'd0, kk, vv ^ bm});
      vv = hfn(256'd0, kk, vv ^ bm);
    end
    vout = vv;
  endtask

  task automatic cfg(input int lane, input logic [255:0] d, input int ss, input int st);
    cfg_lane = LW'(lane); cfg_data = d; cfg_start_step = LG'(ss); cfg_steps = LG'(st);
    cfg_we = 1'b1;
    @(posedge clk); #1 cfg_we = 1'b0;
  endtask

  task automatic rd(input int lane, output logic [255:0] d);
    rd_lane = LW'(lane);
    @(posedge clk); #1 d = rd_data;
  endtask

  // Start a batch (cfg_we may already be raised by the caller) and count to done.
  task automatic run_batch(input int inj, input int probe, input logic [255:0] probe_exp,
                           output int cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0; cyc = 1;
    check("busy_c1", busy, 1);
    while (!done && cyc < 300) begin
      start = (cyc == inj); cfg_we = (cyc == inj);
      @(posedge clk); #1;
      start = 1'b0; cfg_we = 1'b0; cyc++;
      if (cyc == probe) check("rd_prewrite", rd_data, probe_exp);
    end
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
  endtask

  task automatic cmp_reqs(input string tag);
    check({tag, "_nreq"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_req%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  logic [255:0] dat[NL], ev[NL], r, X, Y, A5;
  int ss[NL], st[NL], cyc, n, quiet;

  initial begin
    SEED = {8{32'h5EED1234}};
    ADRS = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD};
    A5 = {32{8'hA5}};
    X = {8{32'h0BAD0001}};
    Y = {8{32'h0BAD0002}};
    for (int i = 0; i < NL; i++) dat[i] = {8{32'hC0DE0000 + 32'(i)}};
    reset = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_lane = '0; cfg_data = '0;
    cfg_start_step = '0; cfg_steps = '0; rd_lane = '0; pub_seed = SEED; adrs_in = ADRS;

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_hs", hash_start, 0);
    check("rst_calls", hash_calls, 0);
    check("rst_rd", rd_data, 0);
    check("rst_hdi", hash_data_in, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Lane addressing: steps {1,0,2,1}, done at 1 + 2*4 + 12*5 = 69
    ss = '{0, 3, 5, 14}; st = '{1, 0, 2, 1};
    exp_q.delete();
    for (int i = 0; i < NL; i++) begin
      cfg(i, dat[i], ss[i], st[i]);
      model_lane(i, ss[i], st[i], dat[i], ev[i]);
    end
    got_q.delete();
    rd_lane = 2'd3;
    run_batch(-1, 10, dat[3], cyc);
    check("t2_cycles", cyc, 69);
    check("t2_err", err, 0);
    check("t2_calls", hash_calls, 12);
    cmp_reqs("t2");
    for (int i = 0; i < NL; i++) begin rd(i, r); check($sformatf("t2_lane%0d", i), r, ev[i]); end

    // Clipping, with lane 0 config written in the start cycle: start 10, steps 9 -> 5 steps
    for (int i = 1; i < NL; i++) cfg(i, dat[i], 0, 0);
    exp_q.delete();
    model_lane(0, 10, 5, X, ev[0]);
    got_q.delete();
    cfg_lane = 2'd0; cfg_data = X; cfg_start_step = 4'd10; cfg_steps = 4'd9; cfg_we = 1'b1;
    run_batch(-1, -1, '0, cyc);
    check("t3_cycles", cyc, 84);
    check("t3_err", err, 1);
    check("t3_calls", hash_calls, 15);
    cmp_reqs("t3");
    rd(0, r); check("t3_lane0", r, ev[0]);
    rd(2, r); check("t3_lane2", r, dat[2]);

    // Zero steps everywhere: no hash traffic, done at 1 + 2*4 = 9, err cleared
    for (int i = 0; i < NL; i++) cfg(i, A5, 15, 0);
    got_q.delete();
    run_batch(-1, -1, '0, cyc);
    check("t4_cycles", cyc, 9);
    check("t4_err", err, 0);
    check("t4_calls", hash_calls, 0);
    check("t4_nreq", got_q.size(), 0);
    for (int i = 0; i < NL; i++) begin rd(i, r); check($sformatf("t4_lane%0d", i), r, A5); end

    // start and cfg_we pulsed mid-batch must be ignored
    ss = '{2, 0, 0, 7}; st = '{2, 0, 1, 0};
    dat[1] = X;
    exp_q.delete();
    for (int i = 0; i < NL; i++) begin
      cfg(i, dat[i], ss[i], st[i]);
      model_lane(i, ss[i], st[i], dat[i], ev[i]);
    end
    got_q.delete();
    cfg_lane = 2'd1; cfg_data = Y; cfg_start_step = 4'd0; cfg_steps = 4'd3;
    rd_lane = 2'd1;
    run_batch(5, 7, X, cyc);
    check("t5_cycles", cyc, 54);
    check("t5_calls", hash_calls, 9);
    cmp_reqs("t5");
    for (int i = 0; i < NL; i++) begin rd(i, r); check($sformatf("t5_lane%0d", i), r, ev[i]); end

    // Reset during WAIT_F of lane 0
    cfg(0, dat[0], 0, 3);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      if (hash_start) n++;
      if (n < 3) begin @(posedge clk); #1; end
    end
    check("t6_f_issue", n, 3);
    @(posedge clk); #1;
    rst_epoch++;
    reset = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_err", err, 0);
    check("t6_hs", hash_start, 0);
    check("t6_calls", hash_calls, 0);
    check("t6_hdi", hash_data_in, 0);
    check("t6_rd", rd_data, 0);
    #2 reset = 1'b1;
    quiet = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (hash_start || busy || done) quiet++;
    end
    check("t6_quiet", quiet, 0);
    check("t6_calls_after", hash_calls, 0);
    rd(0, r); check("t6_lane0_cleared", r, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gen_chain_batch.md
# gen_chain_batch

Batched WOTS chaining engine: runs the XMSS chaining function F over up to NUM_LANES independent chains, each with its own start step and step count, through one shared external hash port. Successor to the single-chain generator. Serves WOTS keygen, sign and pk-from-sig by loading all `len` chains, pulsing `start` and reading results back. Connects to sha256XMSS (or any core honouring the hash handshake below).

## Interface
- WOTS_W, 16: Winternitz parameter, a power of 2 (4, 16, 256).
- WOTS_LOG_W, log2(WOTS_W): step field width.
- NUM_LANES, 67: chains per batch (1..255).
- LANE_W, log2 of NUM_LANES rounded up, minimum 1: lane index width.
- KEY_LEN, 256: hash width n, at least 256.
- XMSS_HASH_PADDING_F, 0: padding word for F.
- XMSS_HASH_PADDING_PRF, 3: padding word for PRF.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; all state clears while low.
- start  in  1  batch start pulse; accepted only in IDLE.
- pub_seed  in  KEY_LEN  PRF key; sampled on accepted start.
- adrs_in  in  256  ADRS template, 8×32-bit words, word0 at [255:224]; sampled on accepted start.
- cfg_we  in  1  lane config write; ignored while busy.
- cfg_lane  in  LANE_W  lane written.
- cfg_data  in  KEY_LEN  chain input value.
- cfg_start_step  in  WOTS_LOG_W  first step index.
- cfg_steps  in  WOTS_LOG_W  number of F applications.
- rd_lane  in  LANE_W  readback index.
- rd_data  out  KEY_LEN  lane value, registered, valid 1 cycle after rd_lane.
- busy  out  1  batch in progress.
- done  out  1  one-cycle pulse at batch end.
- err  out  1  sticky: some lane clipped; cleared on accepted start.
- hash_calls  out  16  hash invocations in current/last batch, saturating.
- hash_start  out  1  one-cycle hash request.
- hash_data_in  out  3*KEY_LEN  {padding, key, payload}; stable from hash_start to hash_done.
- hash_done  in  1  one-cycle result strobe.
- hash_data_out  in  KEY_LEN  hash result, valid with hash_done.

## Operation
- Lane file: NUM_LANES × (KEY_LEN + 2·WOTS_LOG_W) registers; results overwrite cfg_data in place.
- States: IDLE, SETUP, PRF_KEY, WAIT_KEY, PRF_MASK, WAIT_MASK, F_ISSUE, WAIT_F, WRITE, FINISH.
- IDLE→SETUP on start: lane ptr=0, hash_calls=0, err=0.
- SETUP: load lane value v, s=start_step, k=min(steps, WOTS_W−1−start); if k<steps set err. k==0 → WRITE, else → PRF_KEY.
- Per step j (s..s+k−1), ADRS = adrs_in with word5=lane index, word6=j, word7=keyAndMask.
- PRF_KEY: hash {PRF pad, pub_seed, ADRS(mask=0) zero-extended to KEY_LEN}; result → key.
- PRF_MASK: same with mask=1; result → bm.
- F_ISSUE: hash {F pad, key, v XOR bm}; result → v. If more steps → PRF_KEY, else → WRITE.
- WRITE: store v to lane; ptr==NUM_LANES−1 → FINISH, else ptr++ → SETUP.
- FINISH: done=1, busy=0, → IDLE.
- Each issue state drives hash_start for exactly 1 cycle, increments hash_calls, then waits in WAIT_*. hash_done outside WAIT_* is ignored.
- Simultaneous events:
  - start while busy: ignored.
  - cfg_we during FINISH: ignored.
  - cfg_we with start in IDLE: write applies first, batch sees it.
- Reset mid-batch: immediate return to IDLE; in-flight hash result discarded; lane file cleared.

## Timing
- Reset values: busy, done, err, hash_start = 0; hash_calls, rd_data, hash_data_in = 0.
- start sampled at edge 0 → busy=1 from cycle 1.
- L = cycles from hash_start to hash_done (≥1). Each hash call costs 1+L cycles.
- Lane cost: 2 + 3·k·(1+L) cycles (SETUP + hash calls + WRITE).
- done asserted in cycle 1 + Σ lane costs; busy falls in that same cycle.
- Next start is accepted from the cycle after done.
- rd_data is valid for any lane the cycle after rd_lane, including while busy; it returns the pre-write value until that lane's WRITE.

## Test plan
- Reset mid-run: reset low during WAIT_F → all outputs 0 next cycle. A later hash_done produces no activity.
- Golden single chain: NUM_LANES=1, real SHA-256 model, start_step=0, steps=15 → rd_data matches the XMSS reference chain; hash_calls=45.
- Zero steps: NUM_LANES=3, all steps=0, data=0xA5… → no hash_start pulses; done at cycle 7; data unchanged.
- Clipping: start_step=10, steps=9, W=16 → 5 steps; err=1; hash_calls=15.
- Lane addressing, L=4 stub: NUM_LANES=4, steps {1,0,2,1} → 12 hash calls; word5 = lane index on each request; word6/word7 sequence correct; done at cycle 1 + 2·4 + 12·5 = 69.
- Ignored inputs: start and cfg_we pulses while busy → batch result and config unchanged.
